// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, datapath width and instruction field helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic op_uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
    endfunction

    // x0 is hardwired to zero, so a write to it must never be treated as a producer.
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/operand_forward.sv
// Two-level forwarding mux for one EX operand: EX/MEM result first, then MEM/WB, then captured value.
module operand_forward
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] captured,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = captured;
        if (fwd_hit(mem_we, mem_rd, rs)) begin
            operand = mem_data;
        end else if (fwd_hit(wb_we, wb_rd, rs)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing with WB bypass, load-use stall,
// flush handling and final operand forwarding into EX.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_inst,
    output logic [4:0]      addr_rs1,
    output logic [4:0]      addr_rs2,
    input  logic [XLEN-1:0] data_rs1,
    input  logic [XLEN-1:0] data_rs2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_inst,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic            ex_is_load,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b
);

    logic [6:0]      id_opcode;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [XLEN-1:0] id_op_a;
    logic [XLEN-1:0] id_op_b;
    logic [XLEN-1:0] ex_cap_a;
    logic [XLEN-1:0] ex_cap_b;
    logic            rs1_dep;
    logic            rs2_dep;

    assign id_opcode   = inst_opcode(id_inst);
    assign addr_rs1    = inst_rs1(id_inst);
    assign addr_rs2    = inst_rs2(id_inst);
    assign id_uses_rs1 = op_uses_rs1(id_opcode);
    assign id_uses_rs2 = op_uses_rs2(id_opcode);

    // The register file commits on the same edge we capture, so its read data is one write stale.
    assign id_op_a = fwd_hit(wb_we, wb_rd, addr_rs1) ? wb_data : data_rs1;
    assign id_op_b = fwd_hit(wb_we, wb_rd, addr_rs2) ? wb_data : data_rs2;

    assign rs1_dep = id_uses_rs1 && (ex_rd == addr_rs1);
    assign rs2_dep = id_uses_rs2 && (ex_rd == addr_rs2);
    assign stall   = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0)
                     && (rs1_dep || rs2_dep) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_inst    <= '0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_is_load <= 1'b0;
            ex_cap_a   <= '0;
            ex_cap_b   <= '0;
        end else if (flush || stall) begin
            // Bubble: clearing rd/is_load keeps it from forwarding or causing a stall.
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            ex_is_load <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_inst    <= id_inst;
            ex_rd      <= id_valid ? inst_rd(id_inst) : 5'd0;
            ex_rs1     <= addr_rs1;
            ex_rs2     <= addr_rs2;
            ex_is_load <= id_valid && (id_opcode == OP_LOAD);
            ex_cap_a   <= id_op_a;
            ex_cap_b   <= id_op_b;
        end
    end

    operand_forward #(.XLEN(XLEN)) u_fwd_a (
        .rs       (ex_rs1),
        .captured (ex_cap_a),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .operand  (ex_op_a)
    );

    operand_forward #(.XLEN(XLEN)) u_fwd_b (
        .rs       (ex_rs2),
        .captured (ex_cap_b),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .operand  (ex_op_b)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, load-use stall, flush, forwarding priority and reset.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic [31:0] data_rs1;
    logic [31:0] data_rs2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_is_load;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .addr_rs1   (addr_rs1),
        .addr_rs2   (addr_rs2),
        .data_rs1   (data_rs1),
        .data_rs2   (data_rs2),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_inst    (ex_inst),
        .ex_rd      (ex_rd),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_is_load (ex_is_load),
        .ex_op_a    (ex_op_a),
        .ex_op_b    (ex_op_b)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'b0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        id_valid = 1'b0;
        id_pc    = '0;
        id_inst  = '0;
        data_rs1 = '0;
        data_rs2 = '0;
        wb_we    = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        mem_we   = 1'b0;
        mem_rd   = '0;
        mem_data = '0;
        flush    = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_rd",    32'(ex_rd),    32'd0);
        chk("rst_stall",    32'(stall),    32'd0);
        chk("rst_op_a",     ex_op_a,       32'd0);
        chk("rst_op_b",     ex_op_b,       32'd0);
        tick();
        tick();
        reset = 1'b0;

        // WB bypass on capture: add x5,x1,x2 while WB writes x1
        id_valid = 1'b1;
        id_pc    = 32'h0000_0100;
        id_inst  = enc_add(5'd5, 5'd1, 5'd2);
        data_rs1 = 32'h11;
        data_rs2 = 32'h22;
        wb_we    = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'h99;
        #1;
        chk("addr_rs1", 32'(addr_rs1), 32'd1);
        chk("addr_rs2", 32'(addr_rs2), 32'd2);
        chk("byp_stall", 32'(stall), 32'd0);
        tick();
        id_valid = 1'b0;
        wb_we    = 1'b0;
        #1;
        chk("byp_ex_valid", 32'(ex_valid), 32'd1);
        chk("byp_ex_pc",    ex_pc,         32'h0000_0100);
        chk("byp_ex_inst",  ex_inst,       enc_add(5'd5, 5'd1, 5'd2));
        chk("byp_ex_rd",    32'(ex_rd),    32'd5);
        chk("byp_ex_rs1",   32'(ex_rs1),   32'd1);
        chk("byp_ex_rs2",   32'(ex_rs2),   32'd2);
        chk("byp_op_a",     ex_op_a,       32'h99);
        chk("byp_op_b",     ex_op_b,       32'h22);
        chk("byp_is_load",  32'(ex_is_load), 32'd0);

        // Load-use: lw x3,0(x4) then add x6,x3,x7
        id_valid = 1'b1;
        id_pc    = 32'h0000_0104;
        id_inst  = enc_lw(5'd3, 5'd4);
        data_rs1 = 32'h1000;
        tick();
        chk("lu_ex_is_load", 32'(ex_is_load), 32'd1);
        chk("lu_ex_rd",      32'(ex_rd),      32'd3);
        id_pc    = 32'h0000_0108;
        id_inst  = enc_add(5'd6, 5'd3, 5'd7);
        data_rs1 = 32'h5555;
        data_rs2 = 32'h77;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid),   32'd0);
        chk("lu_bubble_rd",    32'(ex_rd),      32'd0);
        chk("lu_bubble_load",  32'(ex_is_load), 32'd0);
        chk("lu_stall_once",   32'(stall),      32'd0);
        tick();
        id_valid = 1'b0;
        wb_we    = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'hABCD;
        #1;
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_pc",    ex_pc,         32'h0000_0108);
        chk("lu_add_rd",    32'(ex_rd),    32'd6);
        chk("lu_op_a",      ex_op_a,       32'hABCD);
        chk("lu_op_b",      ex_op_b,       32'h77);
        wb_we = 1'b0;

        // No false stall; lui/jal chosen so their rs fields alias x3
        id_valid = 1'b1;
        id_inst  = enc_lw(5'd3, 5'd4);
        tick();
        id_inst = {20'h00018, 5'd3, 7'b0110111};
        #1;
        chk("lui_addr_alias", 32'(addr_rs1), 32'd3);
        chk("lui_no_stall",   32'(stall),    32'd0);
        id_inst = {7'b0, 5'd3, 5'd3, 3'b000, 5'd3, 7'b1101111};
        #1;
        chk("jal_no_stall", 32'(stall), 32'd0);
        id_inst = enc_sw(5'd3, 5'd4);
        #1;
        chk("sw_rs2_stall", 32'(stall), 32'd1);
        id_valid = 1'b0;
        #1;
        chk("invalid_no_stall", 32'(stall), 32'd0);

        // Flush wins over a load-use condition
        id_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_ex_rd",    32'(ex_rd),    32'd0);

        // lw x0 never stalls
        id_inst = enc_lw(5'd0, 5'd4);
        tick();
        chk("lw_x0_valid", 32'(ex_valid),   32'd1);
        chk("lw_x0_load",  32'(ex_is_load), 32'd1);
        id_inst = enc_add(5'd6, 5'd0, 5'd0);
        #1;
        chk("lw_x0_no_stall", 32'(stall), 32'd0);

        // Forward priority on ex_rs1=8, x0 on ex_rs2
        id_pc    = 32'h0000_0200;
        id_inst  = enc_add(5'd9, 5'd8, 5'd0);
        data_rs1 = 32'h33;
        data_rs2 = 32'h44;
        tick();
        id_valid = 1'b0;
        mem_we   = 1'b1;
        mem_rd   = 5'd8;
        mem_data = 32'h1;
        wb_we    = 1'b1;
        wb_rd    = 5'd8;
        wb_data  = 32'h2;
        #1;
        chk("fwd_mem_prio", ex_op_a, 32'h1);
        mem_rd = 5'd0;
        #1;
        chk("fwd_wb",      ex_op_a, 32'h2);
        chk("fwd_x0_op_b", ex_op_b, 32'h44);
        wb_we = 1'b0;
        #1;
        chk("fwd_none", ex_op_a, 32'h33);
        mem_we = 1'b0;

        // Asynchronous reset mid-stream while a stall is active
        id_valid = 1'b1;
        id_inst  = enc_lw(5'd3, 5'd4);
        tick();
        id_inst = enc_add(5'd6, 5'd3, 5'd7);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid),   32'd0);
        chk("async_rst_rd",    32'(ex_rd),      32'd0);
        chk("async_rst_load",  32'(ex_is_load), 32'd0);
        chk("async_rst_stall", 32'(stall),      32'd0);
        tick();
        reset    = 1'b0;
        id_valid = 1'b0;
        tick();
        chk("post_rst_idle", 32'(ex_valid), 32'd0);
        id_valid = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_rd",    32'(ex_rd),    32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
